tybec_map_node_vec: RTL and testbench
=====================================

# tybec_map_node_vec

Parametrised, vectorised leaf map node for TyBEC-generated kernels: applies one integer binary operator (mul/add/sub) lane-wise to LANES packed operands, through a LAT-stage pipeline. Generalises the constant-operand leaf node with vector lanes, a selectable operator, and a stream-or-constant second operand. A credit-counted output FIFO provides lossless valid/ready back-pressure. It sits between upstream stream ports and downstream leaf or compound nodes.

## Interface
- DATAW, 32: lane width in bits
- LANES, 2: lanes per transfer
- LAT, 3: pipeline depth, ≥1
- OP, 0: 0 = mul, 1 = add, 2 = sub (in1 − in2)
- CONST_MODE, 0: 1 = second operand is CONST_VAL for every lane, and in2 is ignored
- CONST_VAL, 0: DATAW-bit constant operand
- FIFO_DEPTH, LAT+2: output FIFO entries, ≥1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ivalid  in  1  input transfer valid
- iready  out  1  node can accept; independent of oready within a cycle
- in1  in  LANES*DATAW  operand 1; lane i in bits [i*DATAW +: DATAW]
- in2  in  LANES*DATAW  operand 2, same packing
- ovalid  out  1  out1 holds a valid result
- oready  in  1  downstream accepts
- out1  out  LANES*DATAW  results, same packing

## Operation
- Accept on every edge with ivalid & iready. Pop on every edge with ovalid & oready.
- Lane result: in1_i OP in2_i, in two's complement. Keep the low DATAW bits; overflow wraps silently. mul is signed-agnostic low-half.
- Pipeline: LAT valid/data stages advance every cycle unconditionally. Bubbles carry valid = 0. The stage-LAT result is written into the FIFO.
- Credit counter: CW = clog2(FIFO_DEPTH+1) bits, reset to FIFO_DEPTH.
  - −1 on accept, +1 on pop; simultaneous accept and pop gives a net 0.
  - iready = (credits != 0), driven from the register only.
- Because of the credit scheme, the FIFO never overflows and in-flight data is never dropped.
- ovalid = FIFO not empty. out1 = FIFO head when not empty, all-zero when empty.
- FIFO supports write and read in the same cycle, including when full or empty (write-to-empty becomes visible next cycle).
- Reset, including mid-operation: clears all stage valids, empties the FIFO, and sets credits to FIFO_DEPTH. In-flight data is discarded.
- Reset values: ovalid 0, out1 0, iready 1.

## Timing
- A sample accepted at edge n has out1/ovalid visible after edge n+LAT, provided the FIFO is empty ahead of it.
- Throughput is 1 transfer/cycle with oready held high iff FIFO_DEPTH ≥ LAT+2. A smaller depth throttles iready but never loses data.
- Order is preserved: outputs leave in accept order.
- No combinational path from ivalid/oready to iready/ovalid/out1.
- With oready held low, after FIFO_DEPTH accepts iready stays low until the first pop. The cycle after that pop, iready = 1.

## Structure
- Package tybec_map_pkg: OP_MUL/OP_ADD/OP_SUB localparams and a clog2 function.
- Sub-module tybec_credit_fifo: FIFO storage, head/tail pointers, and the credit counter. Parameters: WIDTH, DEPTH. Ports: push, pop, din, dout, empty, credit_ok.
- The top holds the lane operator generate loop, the LAT pipeline, and the CONST_MODE operand mux.

## Test plan
- Defaults, OP = mul, CONST_MODE = 1, CONST_VAL = 3; in1 lanes {5, −2} at edge 0, oready = 1 → out1 lanes {15, −6}, ovalid = 1 after edge 3 for exactly one cycle.
- OP = add, CONST_MODE = 0, 100 back-to-back random vectors, oready = 1 → one output/cycle, iready never drops, results and order match the model.
- Wrap: OP = sub, in1 = 0, in2 = 1 → 0xFFFFFFFF. OP = mul, in1 = in2 = 0x10000 → 0.
- oready = 0, ivalid = 1 continuously → exactly 5 accepts, then iready = 0. Raise oready → 5 outputs in order, and iready = 1 the cycle after the first pop.
- Random ivalid/oready at 50% each, 1000 vectors → no loss or duplication, in-order, and no output before LAT edges after its accept.
- Assert rst asynchronously mid-stream with 3 in flight → ovalid and out1 go to 0 immediately, iready = 1, nothing from before the reset is ever emitted, and the next vector has latency LAT.

Source files
------------

// File: rtl/tybec_map_pkg.sv
// Shared constants and helpers for the TyBEC vector map node.
package tybec_map_pkg;

  localparam int unsigned OP_MUL = 0;
  localparam int unsigned OP_ADD = 1;
  localparam int unsigned OP_SUB = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/tybec_credit_fifo.sv
// Output FIFO plus credit counter; credits are taken at accept and returned at pop,
// so in-flight pipeline entries always have a reserved slot.
module tybec_credit_fifo
  import tybec_map_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acquire,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             credit_ok
);

  localparam int unsigned CW = clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, credits;
  logic             do_pop, take;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop    = pop & (count != '0);
  assign take      = acquire & (credits != '0);
  assign empty     = (count == '0);
  assign credit_ok = (credits != '0);
  assign dout      = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= CW'(DEPTH);
    end else begin
      if (push)   wr_ptr <= bump(wr_ptr);
      if (do_pop) rd_ptr <= bump(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({take, do_pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

endmodule

// File: rtl/tybec_map_node_vec.sv
// Vectorised leaf map node: lane-wise mul/add/sub through a LAT-stage pipeline
// into a credit-counted output FIFO.
module tybec_map_node_vec
  import tybec_map_pkg::*;
#(
  parameter int unsigned     DATAW      = 32,
  parameter int unsigned     LANES      = 2,
  parameter int unsigned     LAT        = 3,
  parameter int unsigned     OP         = 0,
  parameter int unsigned     CONST_MODE = 0,
  parameter logic [DATAW-1:0] CONST_VAL = '0,
  parameter int unsigned     FIFO_DEPTH = LAT + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ivalid,
  output logic                   iready,
  input  logic [LANES*DATAW-1:0] in1,
  input  logic [LANES*DATAW-1:0] in2,
  output logic                   ovalid,
  input  logic                   oready,
  output logic [LANES*DATAW-1:0] out1
);

  localparam int unsigned W = LANES * DATAW;

  logic [W-1:0]   result;
  logic [LAT-1:0] vld;
  logic [W-1:0]   dat [LAT];
  logic           empty;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATAW-1:0] a, b;
    assign a = in1[i*DATAW +: DATAW];
    assign b = (CONST_MODE != 0) ? CONST_VAL : in2[i*DATAW +: DATAW];
    if (OP == OP_ADD) begin : g_add
      assign result[i*DATAW +: DATAW] = a + b;
    end else if (OP == OP_SUB) begin : g_sub
      assign result[i*DATAW +: DATAW] = a - b;
    end else begin : g_mul
      assign result[i*DATAW +: DATAW] = a * b;
    end
  end

  // Stages advance every cycle; only the valid bit marks real samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int unsigned k = 0; k < LAT; k++) dat[k] <= '0;
    end else begin
      vld[0] <= ivalid & iready;
      dat[0] <= result;
      for (int unsigned k = 1; k < LAT; k++) begin
        vld[k] <= vld[k-1];
        dat[k] <= dat[k-1];
      end
    end
  end

  tybec_credit_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .acquire   (ivalid),
    .push      (vld[LAT-1]),
    .pop       (oready),
    .din       (dat[LAT-1]),
    .dout      (out1),
    .empty     (empty),
    .credit_ok (iready)
  );

  assign ovalid = ~empty;

endmodule

// File: tb/tb_tybec_map_node_vec.sv
// Directed bench for tybec_map_node_vec: four operator configurations share one stimulus.
module tb_tybec_map_node_vec;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst, ivalid, oready;
  logic [63:0] in1, in2;
  logic        iready_mc, ovalid_mc, iready_add, ovalid_add;
  logic        iready_sub, ovalid_sub, iready_mul, ovalid_mul;
  logic [63:0] out_mc, out_add, out_sub, out_mul;

  int          checks = 0, failures = 0;
  int          edge_no = 0, n_acc = 0, n_pop = 0;
  logic [63:0] exp_q [$];
  int          acc_edge_q [$];

  always #5 clk = ~clk;

  tybec_map_node_vec #(.OP(0), .CONST_MODE(1), .CONST_VAL(32'd3)) u_mc (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready_mc), .in1(in1), .in2(in2),
    .ovalid(ovalid_mc), .oready(oready), .out1(out_mc));
  tybec_map_node_vec #(.OP(1), .CONST_MODE(0)) u_add (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready_add), .in1(in1), .in2(in2),
    .ovalid(ovalid_add), .oready(oready), .out1(out_add));
  tybec_map_node_vec #(.OP(2), .CONST_MODE(0)) u_sub (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready_sub), .in1(in1), .in2(in2),
    .ovalid(ovalid_sub), .oready(oready), .out1(out_sub));
  tybec_map_node_vec #(.OP(0), .CONST_MODE(0)) u_mul (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready_mul), .in1(in1), .in2(in2),
    .ovalid(ovalid_mul), .oready(oready), .out1(out_mul));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] add_model(input logic [63:0] a, input logic [63:0] b);
    return {a[63:32] + b[63:32], a[31:0] + b[31:0]};
  endfunction

  // One clock: score the add instance's pop/accept, then advance to #1 after the edge.
  task automatic step();
    logic acc, pp;
    acc = ivalid & iready_add;
    pp  = ovalid_add & oready;
    if (pp) begin
      check("out_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("stream_data", out_add, exp_q[0]);
        check("min_latency", 64'((edge_no - acc_edge_q[0]) >= LAT + 1), 64'd1);
        void'(exp_q.pop_front());
        void'(acc_edge_q.pop_front());
      end
      n_pop++;
    end
    if (acc) begin
      exp_q.push_back(add_model(in1, in2));
      acc_edge_q.push_back(edge_no);
      n_acc++;
    end
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic drain();
    ivalid = 1'b0;
    oready = 1'b1;
    for (int k = 0; k < 12; k++) step();
    check("drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int          base_pop, base_acc, drops, cyc;
    logic [31:0] a;

    rst = 1'b1; ivalid = 1'b0; oready = 1'b0; in1 = '0; in2 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_ovalid", 64'(ovalid_add), 64'd0);
    check("rst_out1", out_add, 64'd0);
    check("rst_iready", 64'(iready_add), 64'd1);
    rst = 1'b0;

    // mul by constant 3: lanes {5, -2}; latency LAT, single-cycle output
    in1 = {32'hFFFF_FFFE, 32'd5};
    in2 = {32'd7, 32'd1};
    ivalid = 1'b1; oready = 1'b1;
    step();
    ivalid = 1'b0;
    check("lat_e0", 64'(ovalid_mc), 64'd0);
    step();
    check("lat_e1", 64'(ovalid_mc), 64'd0);
    step();
    check("lat_e2", 64'(ovalid_mc), 64'd0);
    step();
    check("lat_e3_ovalid", 64'(ovalid_mc), 64'd1);
    check("mulc_out", out_mc, {32'hFFFF_FFFA, 32'd15});
    check("sub_out", out_sub, {32'hFFFF_FFF7, 32'd4});
    check("mul_out", out_mul, {32'hFFFF_FFF2, 32'd5});
    step();
    check("one_cycle_ovalid", 64'(ovalid_mc), 64'd0);
    check("empty_out_zero", out_mc, 64'd0);
    drain();

    // wrap-around: 0-1 and 0x10000*0x10000
    in1 = {32'h0001_0000, 32'h0};
    in2 = {32'h0001_0000, 32'h1};
    ivalid = 1'b1;
    step();
    ivalid = 1'b0;
    step(); step(); step();
    check("wrap_sub", out_sub, {32'h0, 32'hFFFF_FFFF});
    check("wrap_mul_valid", 64'(ovalid_mul), 64'd1);
    check("wrap_mul", out_mul, 64'd0);
    drain();

    // 100 back-to-back vectors with oready high
    base_pop = n_pop; drops = 0;
    for (int i = 0; i < 101 + LAT; i++) begin
      a = 32'(i) * 32'h9E37_79B9;
      in1 = {a, ~a};
      in2 = {a ^ 32'h5A5A_5A5A, 32'(i) << 20};
      ivalid = (i < 100);
      if (ivalid && !iready_add) drops++;
      step();
    end
    check("stream_no_stall", 64'(drops), 64'd0);
    check("stream_outputs", 64'(n_pop - base_pop), 64'd100);
    drain();

    // back-pressure: exactly FIFO_DEPTH accepts, then iready returns after first pop
    base_acc = n_acc;
    oready = 1'b0; ivalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in1 = {32'(i), 32'(i * 3)};
      in2 = {32'(100 + i), 32'd9};
      step();
    end
    check("bp_accepts", 64'(n_acc - base_acc), 64'd5);
    check("bp_iready_low", 64'(iready_add), 64'd0);
    ivalid = 1'b0;
    step(); step();
    check("bp_iready_still_low", 64'(iready_add), 64'd0);
    check("bp_ovalid", 64'(ovalid_add), 64'd1);
    oready = 1'b1;
    step();
    check("bp_iready_after_pop", 64'(iready_add), 64'd1);
    drain();

    // random ivalid/oready at 50%
    base_acc = n_acc; cyc = 0;
    while ((n_acc - base_acc) < 1000 && cyc < 20000) begin
      ivalid = 1'($urandom_range(0, 1));
      oready = 1'($urandom_range(0, 1));
      in1 = {$urandom, $urandom};
      in2 = {$urandom, $urandom};
      step();
      cyc++;
    end
    check("rand_accepts", 64'(n_acc - base_acc), 64'd1000);
    drain();

    // asynchronous reset with entries in the FIFO and the pipeline
    oready = 1'b0; ivalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in1 = {32'(i + 7), 32'(i)};
      in2 = {32'd1, 32'd2};
      step();
    end
    ivalid = 1'b0;
    check("pre_rst_ovalid", 64'(ovalid_add), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_ovalid", 64'(ovalid_add), 64'd0);
    check("arst_out1", out_add, 64'd0);
    check("arst_iready", 64'(iready_add), 64'd1);
    exp_q.delete();
    acc_edge_q.delete();
    #1 rst = 1'b0;
    oready = 1'b1;
    base_pop = n_pop;
    for (int i = 0; i < 8; i++) step();
    check("no_stale_output", 64'(n_pop - base_pop), 64'd0);
    in1 = {32'd40, 32'd2};
    in2 = {32'd2, 32'd40};
    ivalid = 1'b1;
    step();
    ivalid = 1'b0;
    step(); step();
    check("post_rst_lat_e2", 64'(ovalid_add), 64'd0);
    step();
    check("post_rst_lat_e3", 64'(ovalid_add), 64'd1);
    check("post_rst_data", out_add, {32'd42, 32'd42});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
